// File: rtl/cpu_ctrl_core.sv
// ============================================================================
// Module   : cpu_ctrl_core
// Brief    : Control decode, 8:1 common-bus mux and ALU for the 8-bit
//            accumulator CPU; owns only the E (link) and halted flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_ctrl_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        T,
  input  logic [7:0]        IR,
  input  logic [ADDR_W-1:0] AR_DATA,
  input  logic [ADDR_W-1:0] PC_DATA,
  input  logic [DATA_W-1:0] DR_DATA,
  input  logic [DATA_W-1:0] AC_DATA,
  input  logic [DATA_W-1:0] TR_DATA,
  input  logic [DATA_W-1:0] MEMORY_DATA,
  input  logic [DATA_W-1:0] X_DATA,
  output logic              load_AR,
  output logic              load_PC,
  output logic              load_DR,
  output logic              load_AC,
  output logic              load_IR,
  output logic              load_TR,
  output logic              clear_AR,
  output logic              clear_PC,
  output logic              clear_DR,
  output logic              clear_AC,
  output logic              clear_TR,
  output logic              inc_AR,
  output logic              inc_PC,
  output logic              inc_DR,
  output logic              inc_AC,
  output logic              inc_TR,
  output logic              seq_counter_RESET,
  output logic              memory_read,
  output logic              memory_write,
  output logic [2:0]        bus_selectors,
  output logic              alu_enable,
  output logic [2:0]        alu_mode,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              E,
  output logic              halted
);

  localparam logic [2:0] SEL_ALU = 3'd0;
  localparam logic [2:0] SEL_AR  = 3'd1;
  localparam logic [2:0] SEL_PC  = 3'd2;
  localparam logic [2:0] SEL_DR  = 3'd3;
  localparam logic [2:0] SEL_AC  = 3'd4;
  localparam logic [2:0] SEL_IR  = 3'd5;
  localparam logic [2:0] SEL_TR  = 3'd6;
  localparam logic [2:0] SEL_MEM = 3'd7;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_CMA = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  logic [3:0]        w_op;
  logic              w_active;
  logic              w_hlt;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_alu_raw;
  logic              w_carry;
  logic              w_e_load;

  assign w_op = IR[7:4];
  // Malformed timing, reset or halt all collapse to "idle and rewind SC".
  assign w_active = reset && !halted && $onehot(T);

  always_comb begin
    load_AR = 1'b0; load_PC = 1'b0; load_DR = 1'b0;
    load_AC = 1'b0; load_IR = 1'b0; load_TR = 1'b0;
    clear_AR = 1'b0; clear_PC = 1'b0; clear_DR = 1'b0;
    clear_AC = 1'b0; clear_TR = 1'b0;
    inc_AR = 1'b0; inc_PC = 1'b0; inc_DR = 1'b0;
    inc_AC = 1'b0; inc_TR = 1'b0;
    seq_counter_RESET = 1'b0;
    memory_read   = 1'b0;
    memory_write  = 1'b0;
    bus_selectors = SEL_ALU;
    alu_enable    = 1'b0;
    alu_mode      = ALU_ADD;
    w_hlt         = 1'b0;
    if (!w_active) begin
      seq_counter_RESET = 1'b1;
    end else if (T[0]) begin
      bus_selectors = SEL_PC;
      load_AR       = 1'b1;
    end else if (T[1]) begin
      memory_read   = 1'b1;
      bus_selectors = SEL_MEM;
      load_IR       = 1'b1;
      inc_PC        = 1'b1;
    end else if (T[2]) begin
      bus_selectors = SEL_IR;
      load_AR       = 1'b1;
    end else if (T[3]) begin
      case (w_op)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8: begin
          memory_read   = 1'b1;
          bus_selectors = SEL_MEM;
          load_DR       = 1'b1;
        end
        4'h6: begin
          bus_selectors     = SEL_AC;
          memory_write      = 1'b1;
          seq_counter_RESET = 1'b1;
        end
        4'h7: begin
          bus_selectors     = SEL_AR;
          load_PC           = 1'b1;
          seq_counter_RESET = 1'b1;
        end
        4'h9: begin
          clear_AC          = 1'b1;
          seq_counter_RESET = 1'b1;
        end
        4'hA, 4'hC, 4'hD: begin
          alu_enable        = 1'b1;
          alu_mode          = (w_op == 4'hA) ? ALU_CMA : {2'b11, w_op[0]};
          bus_selectors     = SEL_ALU;
          load_AC           = 1'b1;
          seq_counter_RESET = 1'b1;
        end
        4'hB: begin
          inc_AC            = 1'b1;
          seq_counter_RESET = 1'b1;
        end
        4'hE: begin
          inc_PC            = (AC_DATA == '0);
          seq_counter_RESET = 1'b1;
        end
        default: begin
          w_hlt             = 1'b1;
          seq_counter_RESET = 1'b1;
        end
      endcase
    end else if (T[4]) begin
      case (w_op)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
          alu_enable = 1'b1;
          case (w_op)
            4'h0:    alu_mode = ALU_AND;
            4'h1:    alu_mode = ALU_ADD;
            4'h2:    alu_mode = ALU_SUB;
            4'h3:    alu_mode = ALU_OR;
            default: alu_mode = ALU_XOR;
          endcase
          bus_selectors     = SEL_ALU;
          load_AC           = 1'b1;
          seq_counter_RESET = 1'b1;
        end
        4'h5: begin
          bus_selectors     = SEL_DR;
          load_AC           = 1'b1;
          seq_counter_RESET = 1'b1;
        end
        4'h8: inc_DR = 1'b1;
        default: ;
      endcase
    end else if (T[5]) begin
      // ISZ: DR was incremented at T4, so this zero test sees the new value.
      if (w_op == 4'h8) begin
        bus_selectors     = SEL_DR;
        memory_write      = 1'b1;
        inc_PC            = (DR_DATA == '0);
        seq_counter_RESET = 1'b1;
      end
    end
  end

  assign w_sum  = {1'b0, AC_DATA} + {1'b0, DR_DATA};
  assign w_diff = {1'b0, AC_DATA} + {1'b0, ~DR_DATA} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    w_alu_raw = '0;
    w_carry   = 1'b0;
    w_e_load  = 1'b0;
    case (alu_mode)
      ALU_ADD: begin w_alu_raw = w_sum[DATA_W-1:0];  w_carry = w_sum[DATA_W];  w_e_load = 1'b1; end
      ALU_SUB: begin w_alu_raw = w_diff[DATA_W-1:0]; w_carry = w_diff[DATA_W]; w_e_load = 1'b1; end
      ALU_AND: w_alu_raw = AC_DATA & DR_DATA;
      ALU_OR:  w_alu_raw = AC_DATA | DR_DATA;
      ALU_XOR: w_alu_raw = AC_DATA ^ DR_DATA;
      ALU_CMA: w_alu_raw = ~AC_DATA;
      ALU_SHL: begin w_alu_raw = {AC_DATA[DATA_W-2:0], 1'b0}; w_carry = AC_DATA[DATA_W-1]; w_e_load = 1'b1; end
      default: begin w_alu_raw = {1'b0, AC_DATA[DATA_W-1:1]}; w_carry = AC_DATA[0];        w_e_load = 1'b1; end
    endcase
  end

  assign alu_result = alu_enable ? w_alu_raw : '0;

  always_comb begin
    case (bus_selectors)
      SEL_ALU: bus_out = alu_enable ? alu_result : X_DATA;
      SEL_AR:  bus_out = {{(DATA_W-ADDR_W){1'b0}}, AR_DATA};
      SEL_PC:  bus_out = {{(DATA_W-ADDR_W){1'b0}}, PC_DATA};
      SEL_DR:  bus_out = DR_DATA;
      SEL_AC:  bus_out = AC_DATA;
      SEL_IR:  bus_out = IR;
      SEL_TR:  bus_out = TR_DATA;
      default: bus_out = MEMORY_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      E      <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (alu_enable && w_e_load) E <= w_carry;
      if (w_hlt) halted <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_core.sv
// ============================================================================
// Module   : tb_cpu_ctrl_core
// Brief    : Directed plus randomized bench for cpu_ctrl_core against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_ctrl_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] T, IR, DR_DATA, AC_DATA, TR_DATA, MEMORY_DATA, X_DATA;
  logic [3:0] AR_DATA, PC_DATA;
  logic load_AR, load_PC, load_DR, load_AC, load_IR, load_TR;
  logic clear_AR, clear_PC, clear_DR, clear_AC, clear_TR;
  logic inc_AR, inc_PC, inc_DR, inc_AC, inc_TR;
  logic seq_counter_RESET, memory_read, memory_write, alu_enable, E, halted;
  logic [2:0] bus_selectors, alu_mode;
  logic [7:0] bus_out, alu_result;

  cpu_ctrl_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .T(T), .IR(IR),
    .AR_DATA(AR_DATA), .PC_DATA(PC_DATA), .DR_DATA(DR_DATA), .AC_DATA(AC_DATA),
    .TR_DATA(TR_DATA), .MEMORY_DATA(MEMORY_DATA), .X_DATA(X_DATA),
    .load_AR(load_AR), .load_PC(load_PC), .load_DR(load_DR),
    .load_AC(load_AC), .load_IR(load_IR), .load_TR(load_TR),
    .clear_AR(clear_AR), .clear_PC(clear_PC), .clear_DR(clear_DR),
    .clear_AC(clear_AC), .clear_TR(clear_TR),
    .inc_AR(inc_AR), .inc_PC(inc_PC), .inc_DR(inc_DR),
    .inc_AC(inc_AC), .inc_TR(inc_TR),
    .seq_counter_RESET(seq_counter_RESET),
    .memory_read(memory_read), .memory_write(memory_write),
    .bus_selectors(bus_selectors), .alu_enable(alu_enable), .alu_mode(alu_mode),
    .bus_out(bus_out), .alu_result(alu_result), .E(E), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state and per-cycle expectations.
  // load bits {AR,PC,DR,AC,IR,TR}; clear/inc bits {AR,PC,DR,AC,TR}.
  logic       m_e, m_halted;
  logic [5:0] x_load;
  logic [4:0] x_clr, x_inc;
  logic       x_sc, x_mr, x_mw, x_en, x_halt, x_eupd, x_carry;
  logic [2:0] x_sel, x_mode;
  logic [7:0] x_alu, x_bus;

  task automatic predict();
    int step, op, a, d, r;
    x_load = '0; x_clr = '0; x_inc = '0;
    x_sc = 0; x_mr = 0; x_mw = 0; x_en = 0; x_halt = 0; x_eupd = 0; x_carry = 0;
    x_sel = 0; x_mode = 0;
    step = -1;
    for (int i = 0; i < 8; i++) if (T[i]) step = (step < 0) ? i : 99;
    op = int'(IR[7:4]);
    if (!reset || m_halted || step < 0 || step == 99) x_sc = 1;
    else if (step == 0) begin x_sel = 2; x_load[5] = 1; end
    else if (step == 1) begin x_mr = 1; x_sel = 7; x_load[1] = 1; x_inc[3] = 1; end
    else if (step == 2) begin x_sel = 5; x_load[5] = 1; end
    else if (step == 3) begin
      if (op <= 5 || op == 8) begin x_mr = 1; x_sel = 7; x_load[3] = 1; end
      else begin
        x_sc = 1;
        case (op)
          6:  begin x_sel = 4; x_mw = 1; end
          7:  begin x_sel = 1; x_load[4] = 1; end
          9:  x_clr[1] = 1;
          10: begin x_en = 1; x_mode = 5; x_load[2] = 1; end
          12: begin x_en = 1; x_mode = 6; x_load[2] = 1; end
          13: begin x_en = 1; x_mode = 7; x_load[2] = 1; end
          11: x_inc[1] = 1;
          14: x_inc[3] = (AC_DATA == 0);
          default: x_halt = 1;
        endcase
      end
    end else if (step == 4) begin
      if (op <= 4) begin
        x_en = 1; x_load[2] = 1; x_sc = 1;
        case (op) 0: x_mode = 2; 1: x_mode = 0; 2: x_mode = 1; 3: x_mode = 3; default: x_mode = 4; endcase
      end else if (op == 5) begin x_sel = 3; x_load[2] = 1; x_sc = 1; end
      else if (op == 8) x_inc[2] = 1;
    end else if (step == 5 && op == 8) begin
      x_sel = 3; x_mw = 1; x_inc[3] = (DR_DATA == 0); x_sc = 1;
    end
    a = int'(AC_DATA); d = int'(DR_DATA); r = 0;
    if (x_en) begin
      case (x_mode)
        0: begin r = a + d; x_carry = (r > 255); x_eupd = 1; end
        1: begin r = a - d + 256; x_carry = (a >= d); x_eupd = 1; end
        2: r = a & d;
        3: r = a | d;
        4: r = a ^ d;
        5: r = 255 - a;
        6: begin r = a * 2; x_carry = (a >= 128); x_eupd = 1; end
        default: begin r = a / 2; x_carry = (a % 2 == 1); x_eupd = 1; end
      endcase
    end
    x_alu = 8'(r % 256);
    case (x_sel)
      0: x_bus = x_en ? x_alu : X_DATA;
      1: x_bus = {4'h0, AR_DATA};
      2: x_bus = {4'h0, PC_DATA};
      3: x_bus = DR_DATA;
      4: x_bus = AC_DATA;
      5: x_bus = IR;
      6: x_bus = TR_DATA;
      default: x_bus = MEMORY_DATA;
    endcase
  endtask

  task automatic set_in(input logic rv, input logic [7:0] tv, irv, drv, acv);
    @(negedge clk);
    AR_DATA = 4'($urandom); PC_DATA = 4'($urandom); TR_DATA = 8'($urandom);
    MEMORY_DATA = 8'($urandom); X_DATA = 8'($urandom);
    reset = rv; T = tv; IR = irv; DR_DATA = drv; AC_DATA = acv;
  endtask

  task automatic run_cycle();
    if (!reset) begin m_e = 0; m_halted = 0; end
    #1;
    predict();
    check("load", 32'({load_AR, load_PC, load_DR, load_AC, load_IR, load_TR}), 32'(x_load));
    check("clear", 32'({clear_AR, clear_PC, clear_DR, clear_AC, clear_TR}), 32'(x_clr));
    check("inc", 32'({inc_AR, inc_PC, inc_DR, inc_AC, inc_TR}), 32'(x_inc));
    check("sc_reset", 32'(seq_counter_RESET), 32'(x_sc));
    check("mem_rw", 32'({memory_read, memory_write}), 32'({x_mr, x_mw}));
    check("bus_sel", 32'(bus_selectors), 32'(x_sel));
    check("alu_en", 32'(alu_enable), 32'(x_en));
    if (x_en) check("alu_mode", 32'(alu_mode), 32'(x_mode));
    check("alu_result", 32'(alu_result), 32'(x_alu));
    check("bus_out", 32'(bus_out), 32'(x_bus));
    check("E", 32'(E), 32'(m_e));
    check("halted", 32'(halted), 32'(m_halted));
    @(posedge clk);
    if (reset) begin
      if (x_en && x_eupd) m_e = x_carry;
      if (x_halt) m_halted = 1;
    end
  endtask

  initial begin
    m_e = 0; m_halted = 0;
    reset = 0; T = 0; IR = 0; AR_DATA = 0; PC_DATA = 0;
    DR_DATA = 0; AC_DATA = 0; TR_DATA = 0; MEMORY_DATA = 0; X_DATA = 0;

    set_in(0, 8'h08, 8'hF0, 8'h00, 8'h00); run_cycle();
    set_in(1, 8'h01, 8'h00, 8'h00, 8'h00); run_cycle();
    set_in(1, 8'h02, 8'h00, 8'h00, 8'h00); run_cycle();
    // ADD with carry out, then E must be 1.
    set_in(1, 8'h10, 8'h13, 8'h20, 8'hF0); run_cycle();
    set_in(1, 8'h01, 8'h00, 8'h00, 8'h00); #1 check("add_E_const", 32'(E), 32'd1); run_cycle();
    set_in(1, 8'h20, 8'h85, 8'h00, 8'h00); run_cycle();
    set_in(1, 8'h20, 8'h85, 8'h01, 8'h00); run_cycle();
    set_in(1, 8'h08, 8'h70, 8'h00, 8'h00); AR_DATA = 4'hA; run_cycle();
    set_in(1, 8'h00, 8'h00, 8'h00, 8'h00); X_DATA = 8'h5C; run_cycle();
    set_in(1, 8'h18, 8'h10, 8'h00, 8'h00); run_cycle();
    set_in(1, 8'h08, 8'hF0, 8'h00, 8'h00); run_cycle();
    set_in(1, 8'h01, 8'h00, 8'h00, 8'h00); #1 check("halted_const", 32'(halted), 32'd1); run_cycle();
    set_in(0, 8'h01, 8'h00, 8'h00, 8'h00); run_cycle();
    set_in(1, 8'h01, 8'h00, 8'h00, 8'h00); run_cycle();

    for (int n = 0; n < 2000; n++) begin
      logic       rv;
      logic [7:0] tv, irv;
      rv  = ($urandom_range(0, 39) != 0);
      tv  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      irv = 8'($urandom);
      if (irv[7:4] == 4'hF && $urandom_range(0, 2) != 0) irv[7:4] = 4'(n);
      set_in(rv, tv, irv, ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
             ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
